dmem_unloader: RTL and testbench

DMEM_UNLOADER -- requirements
Module: dmem_unloader

---
 rtl/dmem_unloader.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_unloader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_unloader.sv
// ---------------------------------------------------------------------------
// dmem_unloader
//
// Streams the contents of a data memory out on a valid/ready interface. The
// memory layout is the one the loader produces:
//   - word 0 holds the payload count N;
//   - words 1..N hold the payload.
// The payload is streamed in ascending address order, one beat every two
// cycles when the sink is always ready.
//
// N is taken from word0[7:0]. If any bit of word0[63:8] is set, N clamps to 255.
//
// Optional feature (macro DMEM_UNLOAD_CHECKSUM_EN):
//   When the macro is defined, the block XORs every accepted payload word into
//   a running checksum. After the last payload beat it sends one extra beat
//   carrying that checksum, and out_last goes with that beat only. An empty
//   memory (N=0) then yields a single checksum beat of 0.
//   When the macro is undefined, no checksum logic exists, out_last goes with
//   payload word N, and N=0 yields no beats at all.
//
// Ports:
//   clk          in   1  single clock, rising edge
//   reset_n      in   1  synchronous active-low reset
//   start        in   1  begin one unload pass (sampled only in IDLE)
//   d_mem_addra  out  8  registered read address to the data memory
//   d_mem_dout   in  64  read data, one cycle after the address
//   out_data     out 64  streamed word, stable while waiting for out_ready
//   out_valid    out  1  out_data is valid
//   out_ready    in   1  sink accepts the current beat
//   out_last     out  1  final beat of the pass
//   busy         out  1  a pass is in progress
//   done         out  1  one-cycle pulse at the end of a pass
// ---------------------------------------------------------------------------
module dmem_unloader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  d_mem_addra,
  input  logic [63:0] d_mem_dout,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR0,
    CNT,
    RD,
    OUT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  count;       // payload length N of the current pass
  logic [7:0]  count_in;    // N decoded from word 0, clamped
  logic        word_last;   // the held beat is payload word N
  logic        handshake;   // a beat transfers this cycle

`ifdef DMEM_UNLOAD_CHECKSUM_EN
  logic [63:0] checksum;    // XOR of payload words accepted so far
  logic        csum_beat;   // the held beat is the trailing checksum
`endif

  assign handshake = (state == OUT) && out_ready;

  // A nonzero upper part of word 0 means the count cannot fit in 8 bits.
  assign count_in = (|d_mem_dout[63:8]) ? 8'hFF : d_mem_dout[7:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ADDR0;
        end
      end
      ADDR0: begin
        state_next = CNT;
      end
      CNT: begin
        if (count_in == 8'd0) begin
`ifdef DMEM_UNLOAD_CHECKSUM_EN
          state_next = OUT;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = RD;
        end
      end
      RD: begin
        state_next = OUT;
      end
      OUT: begin
        if (out_ready) begin
`ifdef DMEM_UNLOAD_CHECKSUM_EN
          // The beat after the final payload word is the checksum, which
          // is already known, so stay in OUT instead of reading memory.
          if (csum_beat) begin
            state_next = DONE;
          end else if (word_last) begin
            state_next = OUT;
          end else begin
            state_next = RD;
          end
`else
          if (word_last) begin
            state_next = DONE;
          end else begin
            state_next = RD;
          end
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. out_last is qualified with out_valid so a stale flag
  // from the previous pass never shows outside a beat.
  always_comb begin
    out_valid = (state == OUT);
    busy      = (state != IDLE);
    done      = (state == DONE);
`ifdef DMEM_UNLOAD_CHECKSUM_EN
    out_last  = out_valid && csum_beat;
`else
    out_last  = out_valid && word_last;
`endif
  end

  // Datapath.
  // The memory has one cycle of read latency, so the address always runs
  // one step ahead of the state that consumes the data. Address 0 is driven
  // in ADDR0 and address 1 in CNT. This lets RD see word 1. During OUT the
  // address already points at the next word, so the following RD captures
  // it directly. The address only advances while it is below N, so the
  // address stops at N. For N=0 it is pulled back to 0 as soon as the count
  // is known.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_mem_addra <= 8'd0;
      out_data    <= 64'd0;
      count       <= 8'd0;
      word_last   <= 1'b0;
`ifdef DMEM_UNLOAD_CHECKSUM_EN
      checksum    <= 64'd0;
      csum_beat   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_mem_addra <= 8'd0;
            word_last   <= 1'b0;
`ifdef DMEM_UNLOAD_CHECKSUM_EN
            checksum    <= 64'd0;
            csum_beat   <= 1'b0;
`endif
          end
        end
        ADDR0: begin
          d_mem_addra <= 8'd1;
        end
        CNT: begin
          count <= count_in;
          if (count_in == 8'd0) begin
            d_mem_addra <= 8'd0;
`ifdef DMEM_UNLOAD_CHECKSUM_EN
            out_data    <= 64'd0;
            csum_beat   <= 1'b1;
`endif
          end
        end
        RD: begin
          // The word arriving now is the one at the current address.
          out_data  <= d_mem_dout;
          word_last <= (d_mem_addra == count);
          if (d_mem_addra != count) begin
            d_mem_addra <= d_mem_addra + 8'd1;
          end
        end
        OUT: begin
`ifdef DMEM_UNLOAD_CHECKSUM_EN
          if (handshake && !csum_beat) begin
            checksum <= checksum ^ out_data;
            if (word_last) begin
              out_data  <= checksum ^ out_data;
              csum_beat <= 1'b1;
            end
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_unloader.sv
// ---------------------------------------------------------------------------
// tb_dmem_unloader
//
// Scoreboard bench for dmem_unloader. A behavioural memory model answers the
// read port with one cycle of latency. Every pass pushes its expected beat
// list, which is derived from the memory contents, into a queue. A monitor
// pops that queue on each handshake and compares the beat against it. The
// monitor also checks hold stability, first-beat latency, the timing of the
// done pulse, and busy duration. Define DMEM_UNLOAD_CHECKSUM_EN to check the
// checksum build.
// ---------------------------------------------------------------------------
module tb_dmem_unloader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  d_mem_addra;
  logic [63:0] d_mem_dout;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  dmem_unloader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .d_mem_addra (d_mem_addra),
    .d_mem_dout  (d_mem_dout),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory with one cycle of read latency.
  logic [63:0] mem [0:255];
  always @(posedge clk) d_mem_dout <= mem[d_mem_addra];

  // Scoreboard state.
  logic [63:0] exp_data [$];
  logic        exp_last [$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_beats;
  int beat_cnt;
  int done_cnt = 0;
  int done_cyc;
  int last_hs_cyc;
  int first_valid_cyc;
  int busy_cnt;
  int t_start;
  int done_before;
  bit seen_valid;
  bit prev_valid = 0;
  bit prev_ready;
  logic [63:0] prev_data;
  int ready_mode = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference model: build the beat list a pass over the current memory
  // should produce.
  task automatic pushExpected();
    int n;
    logic [63:0] cs;
    cs = 64'd0;
    n = (mem[0][63:8] != 56'd0) ? 255 : int'(mem[0][7:0]);
    for (int i = 1; i <= n; i++) begin
      exp_data.push_back(mem[i]);
`ifdef DMEM_UNLOAD_CHECKSUM_EN
      exp_last.push_back(1'b0);
`else
      exp_last.push_back(i == n);
`endif
      cs = cs ^ mem[i];
    end
`ifdef DMEM_UNLOAD_CHECKSUM_EN
    exp_data.push_back(cs);
    exp_last.push_back(1'b1);
    exp_beats = n + 1;
`else
    exp_beats = n;
`endif
  endtask

  // Monitor: scoreboard pops and protocol checks, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] ed;
    logic        el;
    if (!reset_n) begin
      prev_valid = 0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("hold_data", out_data, prev_data);
      end
      if (!out_valid) checkOutput("last_without_valid", {63'd0, out_last}, 64'd0);
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        last_hs_cyc = cyc;
        if (exp_data.size() == 0) begin
          checkOutput("unexpected_beat", out_data, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          checkOutput("beat_data", out_data, ed);
          checkOutput("beat_last", {63'd0, out_last}, {63'd0, el});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // Random ready generator, active when ready_mode is 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic applyStimulus();
    pushExpected();
    @(posedge clk);
    #1;
    start = 1'b1;
    t_start = cyc;
    seen_valid = 0;
    beat_cnt = 0;
    busy_cnt = 0;
    done_before = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k;
    k = 0;
    while (done_cnt == done_before && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == done_before) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finishPass(input bit timing);
    checkOutput("beat_count", 64'(beat_cnt), 64'(exp_beats));
    checkOutput("sb_empty", 64'(exp_data.size()), 64'd0);
    if (timing && exp_beats > 0) begin
      checkOutput("first_valid_latency", 64'(first_valid_cyc - t_start), 64'd4);
      checkOutput("done_after_last_hs", 64'(done_cyc - last_hs_cyc), 64'd1);
    end
  endtask

  task automatic loadBasic();
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    mem[0] = 64'd3;
    mem[1] = 64'h11;
    mem[2] = 64'h22;
    mem[3] = 64'h33;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_addr"}, {56'd0, d_mem_addra}, 64'd0);
    checkOutput({tag, "_data"}, out_data, 64'd0);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, "_last"}, {63'd0, out_last}, 64'd0);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    loadBasic();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic three-word pass with the sink always ready.
    $display("[TB] basic pass");
    applyStimulus();
    waitDone(50);
    finishPass(1);

    // Backpressure: hold ready low for 5 cycles once the first beat is up.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus();
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("bp_data", out_data, 64'h11);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDone(50);
    finishPass(1);

    // Empty memory.
    $display("[TB] empty pass");
    mem[0] = 64'd0;
    applyStimulus();
    waitDone(50);
    finishPass(1);
`ifdef DMEM_UNLOAD_CHECKSUM_EN
    checkOutput("empty_busy_cycles", 64'(busy_cnt), 64'd4);
`else
    checkOutput("empty_busy_cycles", 64'(busy_cnt), 64'd3);
`endif

    // Count clamp: the upper bits of word 0 are set.
    $display("[TB] clamp pass");
    for (int i = 1; i < 256; i++) mem[i] = 64'(i);
    mem[0] = 64'h100;
    applyStimulus();
    waitDone(700);
    finishPass(1);
    #1;
    checkOutput("clamp_final_addr", {56'd0, d_mem_addra}, 64'd255);

    // Reset during beat 2 aborts the pass without a done pulse.
    $display("[TB] reset abort");
    loadBasic();
    out_ready = 1'b0;
    applyStimulus();
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort_beat2_data", out_data, 64'h22);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_data.delete();
    exp_last.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkIdleOutputs("abort");
    repeat (5) @(posedge clk);
    checkOutput("abort_no_done", 64'(done_cnt), 64'(done_before));
    applyStimulus();
    waitDone(50);
    finishPass(1);

    // Random payloads with random backpressure. A start pulse is issued
    // mid-pass and must be ignored.
    $display("[TB] random passes");
    ready_mode = 1;
    for (int p = 0; p < 6; p++) begin
      mem[0] = 64'($urandom_range(1, 12));
      for (int i = 1; i <= 12; i++) mem[i] = {$urandom, $urandom};
      applyStimulus();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(400);
      finishPass(1);
    end
    ready_mode = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Start held high runs back-to-back passes.
    $display("[TB] start held high");
    mem[0] = 64'd2;
    pushExpected();
    pushExpected();
    done_before = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    k = 0;
    while (done_cnt < done_before + 2 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    start = 1'b0;
    checkOutput("held_done_count", 64'(done_cnt - done_before), 64'd2);
    repeat (4) @(posedge clk);
    checkOutput("held_sb_empty", 64'(exp_data.size()), 64'd0);
    checkOutput("held_idle_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
